adc_sdo_responder: RTL and testbench

- Responder end of the serial ADC link: emulates the 16-bit conversion ADC whose convert/SCK/SDO protocol is driven by our ADC controller.
- Watches adc_convert and adc_sck from the controller and drives adc_sdo with a captured sample, MSB first.
- Used for on-board loopback self-test of the power-peak path and as the bench ADC model; sits where the physical ADC would be.

---
 rtl/adc_sdo_responder.sv | 162 ++++++++++++++++
 tb/tb_adc_sdo_responder.sv | 303 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/adc_sdo_responder.sv
// adc_sdo_responder: emulates a 16-bit conversion ADC on the convert/SCK/SDO
// link. A synchronized convert rising edge captures a sample, holds busy for
// CONV_CYCLES clocks, then shifts the sample out MSB first on SCK falling edges.
// Optional build macro ADC_RESP_RAMP_EN adds pattern_sel and an internal ramp
// source that can replace sample_value as the captured word.
module adc_sdo_responder #(
  parameter int DATA_W      = 16,
  parameter int CONV_CYCLES = 40,
  parameter int SYNC_STAGES = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              adc_convert,
  input  logic              adc_sck,
  output logic              adc_sdo,
  input  logic [DATA_W-1:0] sample_value,
  input  logic              clear_err,
  output logic              busy,
  output logic              frame_done,
  output logic              early_sck_err,
  output logic [7:0]        overrun_count
`ifdef ADC_RESP_RAMP_EN
  ,
  input  logic              pattern_sel
`endif
);

  localparam int CNT_W = (CONV_CYCLES > 1) ? $clog2(CONV_CYCLES) : 1;
  localparam int BIT_W = (DATA_W > 2) ? $clog2(DATA_W) : 1;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(CONV_CYCLES - 1);
  localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(DATA_W - 1);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] CONV  = 2'd1;
  localparam logic [1:0] SHIFT = 2'd2;

  logic [1:0]             state;
  logic [SYNC_STAGES-1:0] conv_sync;
  logic [SYNC_STAGES-1:0] sck_sync;
  logic                   conv_d;
  logic                   sck_d;
  logic                   conv_rise;
  logic                   sck_fall;
  logic                   sck_edge;
  logic [DATA_W-1:0]      shift;
  logic [DATA_W-1:0]      capture_value;
  logic [CNT_W-1:0]       cnt;
  logic [BIT_W-1:0]       bit_cnt;

  // Synchronizer chains plus one extra registered copy for edge detection
  always_ff @(posedge clk) begin
    if (rst) begin
      conv_sync <= '0;
      sck_sync  <= '0;
      conv_d    <= 1'b0;
      sck_d     <= 1'b0;
    end else begin
      conv_sync <= {conv_sync[SYNC_STAGES-2:0], adc_convert};
      sck_sync  <= {sck_sync[SYNC_STAGES-2:0], adc_sck};
      conv_d    <= conv_sync[SYNC_STAGES-1];
      sck_d     <= sck_sync[SYNC_STAGES-1];
    end
  end

  // Edge strobes taken from the last synchronizer stage
  always_comb begin
    conv_rise = conv_sync[SYNC_STAGES-1] & ~conv_d;
    sck_fall  = ~sck_sync[SYNC_STAGES-1] & sck_d;
    sck_edge  = sck_sync[SYNC_STAGES-1] ^ sck_d;
  end

`ifdef ADC_RESP_RAMP_EN
  logic [DATA_W-1:0] ramp;

  // Ramp source advances only when it is the word being captured
  always_ff @(posedge clk) begin
    if (rst) begin
      ramp <= '0;
    end else if (conv_rise && pattern_sel) begin
      ramp <= ramp + DATA_W'(1);
    end
  end

  // Select the word captured on a convert edge
  always_comb begin
    capture_value = pattern_sel ? ramp : sample_value;
  end
`else
  // Select the word captured on a convert edge
  always_comb begin
    capture_value = sample_value;
  end
`endif

  // Main sequencer: a convert edge in any state restarts conversion
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      adc_sdo    <= 1'b0;
      busy       <= 1'b0;
      frame_done <= 1'b0;
      shift      <= '0;
      cnt        <= '0;
      bit_cnt    <= '0;
    end else begin
      frame_done <= 1'b0;
      if (conv_rise) begin
        shift   <= capture_value;
        cnt     <= CNT_LOAD;
        busy    <= 1'b1;
        adc_sdo <= 1'b0;
        state   <= CONV;
      end else begin
        case (state)
          CONV: begin
            if (cnt == '0) begin
              busy    <= 1'b0;
              adc_sdo <= shift[DATA_W-1];
              bit_cnt <= '0;
              state   <= SHIFT;
            end else begin
              cnt <= cnt - CNT_W'(1);
            end
          end
          SHIFT: begin
            if (sck_fall) begin
              if (bit_cnt < BIT_LAST) begin
                shift   <= {shift[DATA_W-2:0], 1'b0};
                adc_sdo <= shift[DATA_W-2];
                bit_cnt <= bit_cnt + BIT_W'(1);
              end else begin
                adc_sdo    <= 1'b0;
                frame_done <= 1'b1;
                state      <= IDLE;
              end
            end
          end
          default: begin
            adc_sdo <= 1'b0;
            state   <= IDLE;
          end
        endcase
      end
    end
  end

  // Sticky early-SCK flag and saturating overrun counter; clear has priority
  always_ff @(posedge clk) begin
    if (rst || clear_err) begin
      early_sck_err <= 1'b0;
      overrun_count <= '0;
    end else begin
      if (state == CONV && sck_edge && !conv_rise) begin
        early_sck_err <= 1'b1;
      end
      if (conv_rise && state != IDLE && overrun_count != 8'hFF) begin
        overrun_count <= overrun_count + 8'd1;
      end
    end
  end

endmodule

// File: tb/tb_adc_sdo_responder.sv
// Self-checking bench for adc_sdo_responder: a behavioural reference model
// (sample-history delay plus protocol rules on a captured word) is compared
// to the DUT every clock, alongside directed literal checks and random traffic.
module tb_adc_sdo_responder;
  localparam int DW = 16;
  localparam int CC = 40;
  localparam int S  = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        adc_convert = 1'b0;
  logic        adc_sck = 1'b0;
  logic        clear_err = 1'b0;
  logic [15:0] sample_value = '0;
  logic        adc_sdo, busy, frame_done, early_sck_err;
  logic [7:0]  overrun_count;
`ifdef ADC_RESP_RAMP_EN
  logic        pattern_sel = 1'b0;
`endif

  int tests = 0;
  int fails = 0;
  int fd_count = 0;

  always #5 clk = ~clk;

  adc_sdo_responder #(.DATA_W(DW), .CONV_CYCLES(CC), .SYNC_STAGES(S)) dut (
    .clk(clk), .rst(rst), .adc_convert(adc_convert), .adc_sck(adc_sck),
    .adc_sdo(adc_sdo), .sample_value(sample_value), .clear_err(clear_err),
    .busy(busy), .frame_done(frame_done), .early_sck_err(early_sck_err),
    .overrun_count(overrun_count)
`ifdef ADC_RESP_RAMP_EN
    , .pattern_sel(pattern_sel)
`endif
  );

  function automatic void check(string nm, int got, int exp);
    tests++;
    if (got != exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, got, exp, $time);
    end
  endfunction

  // Reference model: mode 0 idle, 1 converting, 2 shifting
  int          m_mode, m_left, m_idx, m_ovr;
  logic [15:0] m_word, m_ramp;
  logic        m_sdo, m_busy, m_fd, m_err;
  bit          m_ok = 1'b0;
  logic        mc [1:S+1];
  logic        ms [1:S+1];

  always @(posedge clk) begin
    if (rst) begin
      for (int a = 1; a <= S + 1; a++) begin
        mc[a] = 1'b0;
        ms[a] = 1'b0;
      end
      m_mode = 0; m_left = 0; m_idx = 0; m_ovr = 0; m_word = '0; m_ramp = '0;
      m_sdo = 0; m_busy = 0; m_fd = 0; m_err = 0;
      m_ok = 1'b1;
    end else begin
      // inputs sampled S and S+1 clocks ago decide this clock's events
      bit crise, sfall, sedge;
      crise = mc[S] && !mc[S+1];
      sfall = !ms[S] && ms[S+1];
      sedge = ms[S] != ms[S+1];
      m_fd = 0;
      if (crise) begin
        if (m_mode != 0 && m_ovr < 255) m_ovr++;
`ifdef ADC_RESP_RAMP_EN
        if (pattern_sel) begin
          m_word = m_ramp;
          m_ramp = m_ramp + 16'd1;
        end else m_word = sample_value;
`else
        m_word = sample_value;
`endif
        m_left = CC - 1; m_mode = 1; m_busy = 1; m_sdo = 0;
      end else if (m_mode == 1) begin
        if (sedge) m_err = 1;
        if (m_left == 0) begin
          m_busy = 0; m_mode = 2; m_idx = 0; m_sdo = m_word[DW-1];
        end else m_left--;
      end else if (m_mode == 2 && sfall) begin
        if (m_idx < DW - 1) begin
          m_idx++;
          m_sdo = m_word[DW-1-m_idx];
        end else begin
          m_sdo = 0; m_fd = 1; m_mode = 0;
        end
      end
      if (clear_err) begin
        m_err = 0; m_ovr = 0;
      end
      for (int a = S + 1; a >= 2; a--) begin
        mc[a] = mc[a-1];
        ms[a] = ms[a-1];
      end
      mc[1] = adc_convert;
      ms[1] = adc_sck;
    end
  end

  // Per-cycle comparison against the model
  always @(negedge clk) begin
    if (m_ok) begin
      if (m_mode != 1) check("sdo", adc_sdo, m_sdo);
      check("busy", busy, m_busy);
      check("frame_done", frame_done, m_fd);
      check("early_sck_err", early_sck_err, m_err);
      check("overrun_count", overrun_count, m_ovr);
      if (frame_done === 1'b1) fd_count++;
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic start_conv(input logic [15:0] v);
    sample_value = v;
    adc_convert = 1'b1;
    tick(3);
    adc_convert = 1'b0;
  endtask

  task automatic wait_busy_done(input string nm);
    int c;
    c = 0;
    while (busy && c < 200) begin
      tick(1);
      c++;
    end
    check({nm, "_busy_timeout"}, busy, 0);
  endtask

  task automatic read_bits(input int half, input int n, output logic [15:0] w);
    w = '0;
    for (int i = 0; i < n; i++) begin
      adc_sck = 1'b1;
      w = {w[14:0], adc_sdo};
      tick(half);
      adc_sck = 1'b0;
      tick(half);
    end
  endtask

  task automatic do_frame(input logic [15:0] v, input logic [15:0] exp,
                          input int half, input string nm);
    int f0;
    logic [15:0] w;
    f0 = fd_count;
    start_conv(v);
    wait_busy_done(nm);
    read_bits(half, 16, w);
    tick(6);
    check({nm, "_data"}, w, exp);
    check({nm, "_fd_pulses"}, fd_count - f0, 1);
    check({nm, "_sdo_idle"}, adc_sdo, 0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] w;
    logic [15:0] last;
    int n, f0, tc, ts;

    tick(3);
    rst = 1'b0;
    check("rst_sdo", adc_sdo, 0);
    check("rst_busy", busy, 0);
    check("rst_ovr", overrun_count, 0);
    tick(2);

`ifdef ADC_RESP_RAMP_EN
    pattern_sel = 1'b1;
    for (int k = 0; k < 4; k++) do_frame(16'($urandom), 16'(k), 4, "ramp");
    pattern_sel = 1'b0;
`endif

    // basic frame with busy-length measurement
    f0 = fd_count;
    sample_value = 16'hA5C3;
    adc_convert = 1'b1;
    n = 0;
    for (int c = 0; c < 200; c++) begin
      @(negedge clk);
      if (c == 2) adc_convert = 1'b0;
      if (busy) n++;
      else if (n > 0) break;
    end
    check("busy_len", n, 40);
    read_bits(4, 16, w);
    tick(6);
    check("a5c3_data", w, 16'hA5C3);
    check("a5c3_fd_pulses", fd_count - f0, 1);
    check("a5c3_err", early_sck_err, 0);
    check("a5c3_sdo_idle", adc_sdo, 0);

    do_frame(16'h0000, 16'h0000, 4, "zeros");
    do_frame(16'hFFFF, 16'hFFFF, 4, "ones");
    do_frame(16'h8001, 16'h8001, 5, "ends");

    // SCK activity during conversion
    start_conv(16'h6E21);
    for (int k = 0; k < 4; k++) begin
      tick(4);
      adc_sck = ~adc_sck;
    end
    tick(4);
    check("early_err_set", early_sck_err, 1);
    wait_busy_done("early");
    read_bits(4, 16, w);
    tick(6);
    check("early_data", w, 16'h6E21);
    check("early_err_sticky", early_sck_err, 1);
    clear_err = 1'b1;
    tick(1);
    clear_err = 1'b0;
    tick(1);
    check("early_err_cleared", early_sck_err, 0);

    // overrun after 5 bits
    f0 = fd_count;
    start_conv(16'h1234);
    wait_busy_done("ovr1");
    read_bits(4, 5, w);
    start_conv(16'h5A5A);
    check("ovr_count1", overrun_count, 1);
    check("ovr_no_fd", fd_count - f0, 0);
    wait_busy_done("ovr2");
    read_bits(4, 16, w);
    tick(6);
    check("ovr_new_data", w, 16'h5A5A);
    check("ovr_fd_pulses", fd_count - f0, 1);

    // saturation: first pulse starts from idle, 299 overruns follow
    for (int k = 0; k < 300; k++) begin
      last = 16'($urandom);
      start_conv(last);
      tick(3);
    end
    check("ovr_saturated", overrun_count, 255);
    clear_err = 1'b1;
    tick(1);
    clear_err = 1'b0;
    check("ovr_cleared", overrun_count, 0);
    wait_busy_done("sat");
    read_bits(4, 16, w);
    tick(6);
    check("sat_last_data", w, last);

    // reset mid-frame at bit 7
    start_conv(16'hFFFF);
    wait_busy_done("rstmid");
    read_bits(4, 7, w);
    check("rstmid_sdo_before", adc_sdo, 1);
    rst = 1'b1;
    tick(1);
    check("rstmid_sdo", adc_sdo, 0);
    check("rstmid_busy", busy, 0);
    rst = 1'b0;
    tick(2);
    do_frame(16'h3C96, 16'h3C96, 4, "post_rst");

    // random frames
    for (int k = 0; k < 6; k++) begin
      last = 16'($urandom);
      do_frame(last, last, $urandom_range(4, 7), "rand_frame");
    end

    // random traffic, checked cycle by cycle against the model
    tc = 1; ts = 4;
    for (int c = 0; c < 3000; c++) begin
      tc--; ts--;
      if (tc <= 0) begin
        adc_convert = ~adc_convert;
        tc = $urandom_range(20, 400);
      end
      if (ts <= 0) begin
        adc_sck = ~adc_sck;
        ts = $urandom_range(4, 10);
      end
      clear_err = ($urandom_range(0, 40) == 0);
      sample_value = 16'($urandom);
      tick(1);
    end
    adc_convert = 1'b0;
    adc_sck = 1'b0;
    clear_err = 1'b0;
    tick(10);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
